// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state encoding for the UART transmit buffer
//
// Purpose: single place for the UART byte width, the default buffer depth and
// the sequencer state encoding used by uart_tx_fifo_ctrl.
// Contents:
//   UART_DATA_W  byte width of the transmit path (fixed at 8)
//   UART_DEPTH   default FIFO depth
//   tx_state_e   sequencer states IDLE / START / WAIT
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_ctrl_if.sv
// rtl/uart_tx_fifo_ctrl_if.sv - producer/transmitter-facing signal bundle of the transmit buffer
//
// Purpose: groups the write port, the status flags and the transmitter
// handshake of uart_tx_fifo_ctrl.
// Signals:
//   wr_en, wr_data         producer write strobe and byte
//   full, empty, level     buffer status (level is 0..DEPTH)
//   overflow               one-cycle pulse for a write rejected while full
//   tx_start, tx_data_in   start pulse and held byte towards the transmitter
//   tx_done                completion pulse from the transmitter
//   busy                   sequencer is not idle
// Modports:
//   slave   the buffer/sequencer itself
//   master  the environment (producer + transmitter)
interface uart_tx_fifo_ctrl_if
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = UART_DATA_W
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data_in;
  logic              tx_done;
  logic              busy;

  modport slave (
    input  wr_en, wr_data, tx_done,
    output full, empty, level, overflow, tx_start, tx_data_in, busy
  );

  modport master (
    output wr_en, wr_data, tx_done,
    input  full, empty, level, overflow, tx_start, tx_data_in, busy
  );

endinterface : uart_tx_fifo_ctrl_if

// File: rtl/uart_tx_fifo_ctrl_sync_fifo.sv
// rtl/uart_tx_fifo_ctrl_sync_fifo.sv - synchronous FIFO with occupancy count and overflow pulse
//
// Purpose: byte storage for the transmit buffer. Occupancy is tracked by a
// registered level counter, which alone separates full from empty.
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   wr_en_i          write strobe; ignored (and flagged) while full
//   wr_data_i        byte to store
//   rd_en_i          pop request; ignored while empty
//   rd_data_o        head of the queue (combinational read)
//   full_o, empty_o  decoded from the registered level
//   level_o          occupancy 0..DEPTH
//   overflow_o       high for the cycle after a write hit a full FIFO
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LEVEL_ONE  = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              push;
  logic              pop;

  // Flags come from the registered level, so a write into a full FIFO is
  // rejected even when a pop happens in the same cycle.
  assign full_o  = (level_q == LEVEL_FULL);
  assign empty_o = (level_q == '0);
  assign push    = wr_en_i & ~full_o;
  assign pop     = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    overflow_d = wr_en_i & full_o;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; resetting the pointers and level discards it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule : sync_fifo

// File: rtl/uart_tx_fifo_ctrl.sv
// rtl/uart_tx_fifo_ctrl.sv - transmit byte buffer and start/done sequencer ahead of the UART transmitter
//
// Purpose: buffers producer bytes and hands them to the transmitter one at a
// time: pop into tx_data_in, pulse tx_start for one cycle, then wait for
// tx_done before popping the next byte.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   uart_tx_fifo_ctrl_if.slave (write port, status, transmitter handshake)
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_fifo_ctrl_if.slave    bus
);

  tx_state_e              state_q;
  logic                   tx_start_q;
  logic                   busy_q;
  logic [UART_DATA_W-1:0] tx_data_q;

  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ADDR_W:0]        fifo_level;
  logic                   fifo_overflow;
  logic                   pop;

  // The head is consumed on the same edge that moves IDLE -> START, so the
  // byte is already in tx_data_q when tx_start rises.
  assign pop = (state_q == IDLE) & ~fifo_empty;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wr_en),
    .wr_data_i  (bus.wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level),
    .overflow_o (fifo_overflow)
  );

  // tx_done is only honoured in WAIT; in IDLE or START it is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            tx_data_q  <= fifo_rd_data;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.full       = fifo_full;
  assign bus.empty      = fifo_empty;
  assign bus.level      = fifo_level;
  assign bus.overflow   = fifo_overflow;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data_in = tx_data_q;
  assign bus.busy       = busy_q;

endmodule : uart_tx_fifo_ctrl
